// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle control unit.
// States, opcodes, datapath select codes, strobe bundle.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_WB_ALU   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_WB_MEM   = 4'd7,
    S_MEM_WR   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_HALT     = 4'd11,
    S_ERROR    = 4'd12
  } state_e;

  typedef enum logic [2:0] {
    C_R    = 3'd0,
    C_I    = 3'd1,
    C_LW   = 3'd2,
    C_SW   = 3'd3,
    C_BR   = 3'd4,
    C_JMP  = 3'd5,
    C_HALT = 3'd6,
    C_ILL  = 3'd7
  } op_class_e;

  localparam logic [3:0] OP_R    = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'h1;
  localparam logic [3:0] OP_LW   = 4'h2;
  localparam logic [3:0] OP_SW   = 4'h3;
  localparam logic [3:0] OP_BEQ  = 4'h4;
  localparam logic [3:0] OP_BLT  = 4'h5;
  localparam logic [3:0] OP_BNE  = 4'h6;
  localparam logic [3:0] OP_BGE  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  localparam logic [1:0] PCS_ALU = 2'b00;
  localparam logic [1:0] PCS_BR  = 2'b01;
  localparam logic [1:0] PCS_JMP = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_isbranch;
    logic [1:0] branch_type;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       halted;
    logic       error;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Control-to-datapath bundle: opcode and memory
// handshake in, PC control and datapath strobes out.
interface multicycle_control_if #(
  parameter int OPCODE_W = 4
);
  logic [OPCODE_W-1:0] input_opcode;
  logic                input_mem_ready;
  logic                output_PCWrite;
  logic                output_PC_isbranch;
  logic [1:0]          output_branchType;
  logic [1:0]          output_PCSource;
  logic                output_IorD;
  logic                output_MemRead;
  logic                output_MemWrite;
  logic                output_IRWrite;
  logic                output_RegWrite;
  logic                output_MemtoReg;
  logic                output_ALUSrcA;
  logic [1:0]          output_ALUSrcB;
  logic [1:0]          output_ALUOp;
  logic                output_halted;
  logic                output_error;

  modport master (
    input  input_opcode,
    input  input_mem_ready,
    output output_PCWrite,
    output output_PC_isbranch,
    output output_branchType,
    output output_PCSource,
    output output_IorD,
    output output_MemRead,
    output output_MemWrite,
    output output_IRWrite,
    output output_RegWrite,
    output output_MemtoReg,
    output output_ALUSrcA,
    output output_ALUSrcB,
    output output_ALUOp,
    output output_halted,
    output output_error
  );

  modport slave (
    output input_opcode,
    output input_mem_ready,
    input  output_PCWrite,
    input  output_PC_isbranch,
    input  output_branchType,
    input  output_PCSource,
    input  output_IorD,
    input  output_MemRead,
    input  output_MemWrite,
    input  output_IRWrite,
    input  output_RegWrite,
    input  output_MemtoReg,
    input  output_ALUSrcA,
    input  output_ALUSrcB,
    input  output_ALUOp,
    input  output_halted,
    input  output_error
  );
endinterface

// File: rtl/multicycle_control_ctrl_decode.sv
// Opcode classifier: maps the IR opcode to the
// next-state class and the branch condition type.
module ctrl_decode
  import multicycle_control_pkg::*;
#(
  parameter int OPCODE_W = 4
) (
  input  logic [OPCODE_W-1:0] opcode_i,
  output op_class_e           class_o,
  output logic [1:0]          btype_o
);

  // Branch opcodes 4..7 carry their condition in the low bits
  assign btype_o = opcode_i[1:0];

  // One-hot compare against each legal opcode
  always_comb begin
    class_o = C_ILL;
    unique case (1'b1)
      (opcode_i == OPCODE_W'(OP_R)):    class_o = C_R;
      (opcode_i == OPCODE_W'(OP_ADDI)): class_o = C_I;
      (opcode_i == OPCODE_W'(OP_LW)):   class_o = C_LW;
      (opcode_i == OPCODE_W'(OP_SW)):   class_o = C_SW;
      (opcode_i == OPCODE_W'(OP_BEQ)) ||
      (opcode_i == OPCODE_W'(OP_BLT)) ||
      (opcode_i == OPCODE_W'(OP_BNE)) ||
      (opcode_i == OPCODE_W'(OP_BGE)):  class_o = C_BR;
      (opcode_i == OPCODE_W'(OP_JMP)):  class_o = C_JMP;
      (opcode_i == OPCODE_W'(OP_HALT)): class_o = C_HALT;
      default:                          class_o = C_ILL;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle main control FSM with memory ready
// handshake, bounded wait timeout and sticky halt/error.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int OPCODE_W    = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input logic CLK,
  input logic RST_N,
  multicycle_control_if.master bus
);

  localparam int CNT_W =
    (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIM =
    CNT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ctrl_t            out_q, out_d;
  op_class_e        cls;
  logic [1:0]       btype;
  logic             mem_req;
  logic             mem_go;
  logic             mem_wait;
  logic             expired;
  logic             ifetch;

  ctrl_decode #(
    .OPCODE_W (OPCODE_W)
  ) u_dec (
    .opcode_i (bus.input_opcode),
    .class_o  (cls),
    .btype_o  (btype)
  );

  // A request is live only while its strobe is actually
  // on the bus, so ready in the reset-release cycle or in
  // non-memory states is ignored.
  assign mem_req  = out_q.mem_read | out_q.mem_write;
  assign mem_go   = mem_req & bus.input_mem_ready;
  assign mem_wait = mem_req & ~bus.input_mem_ready;
  assign expired  = mem_wait && (MEM_TIMEOUT != 0)
                    && (cnt_q == CNT_LIM);
  assign ifetch   = (state_q == S_FETCH) & mem_go;

  // State, wait counter and registered strobes
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  // Next state; counter restarts on every state change
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH: begin
        if (mem_go)       state_d = S_DECODE;
        else if (expired) state_d = S_ERROR;
      end
      S_DECODE: begin
        unique case (cls)
          C_R:     state_d = S_EXEC_R;
          C_I:     state_d = S_EXEC_I;
          C_LW:    state_d = S_MEM_ADDR;
          C_SW:    state_d = S_MEM_ADDR;
          C_BR:    state_d = S_BRANCH;
          C_JMP:   state_d = S_JUMP;
          C_HALT:  state_d = S_HALT;
          default: state_d = S_ERROR;
        endcase
      end
      S_EXEC_R:   state_d = S_WB_ALU;
      S_EXEC_I:   state_d = S_WB_ALU;
      S_WB_ALU:   state_d = S_FETCH;
      S_MEM_ADDR: begin
        state_d = (cls == C_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        if (mem_go)       state_d = S_WB_MEM;
        else if (expired) state_d = S_ERROR;
      end
      S_WB_MEM:   state_d = S_FETCH;
      S_MEM_WR: begin
        if (mem_go)       state_d = S_FETCH;
        else if (expired) state_d = S_ERROR;
      end
      S_BRANCH:   state_d = S_FETCH;
      S_JUMP:     state_d = S_FETCH;
      S_HALT:     state_d = S_HALT;
      S_ERROR:    state_d = S_ERROR;
      default:    state_d = S_ERROR;
    endcase
    cnt_d = '0;
    if (state_d == state_q) begin
      cnt_d = cnt_q
        + CNT_W'(mem_wait && (MEM_TIMEOUT != 0));
    end
  end

  // Strobes for the state being entered, so they are
  // registered and line up with state_q next cycle
  always_comb begin
    out_d = '0;
    unique case (state_d)
      S_FETCH: begin
        out_d.mem_read  = 1'b1;
        out_d.alusrcb   = SRCB_ONE;
        out_d.aluop     = ALU_ADD;
        out_d.pc_source = PCS_ALU;
      end
      S_DECODE: begin
        out_d.alusrcb = SRCB_BOFF;
        out_d.aluop   = ALU_ADD;
      end
      S_EXEC_R: begin
        out_d.alusrca = 1'b1;
        out_d.alusrcb = SRCB_REG;
        out_d.aluop   = ALU_FUNCT;
      end
      S_EXEC_I, S_MEM_ADDR: begin
        out_d.alusrca = 1'b1;
        out_d.alusrcb = SRCB_IMM;
        out_d.aluop   = ALU_ADD;
      end
      S_WB_ALU: out_d.reg_write = 1'b1;
      S_MEM_RD: begin
        out_d.iord     = 1'b1;
        out_d.mem_read = 1'b1;
      end
      S_WB_MEM: begin
        out_d.reg_write = 1'b1;
        out_d.memtoreg  = 1'b1;
      end
      S_MEM_WR: begin
        out_d.iord      = 1'b1;
        out_d.mem_write = 1'b1;
      end
      S_BRANCH: begin
        out_d.alusrca     = 1'b1;
        out_d.alusrcb     = SRCB_REG;
        out_d.aluop       = ALU_SUB;
        out_d.pc_write    = 1'b1;
        out_d.pc_isbranch = 1'b1;
        out_d.pc_source   = PCS_BR;
        out_d.branch_type = btype;
      end
      S_JUMP: begin
        out_d.pc_write  = 1'b1;
        out_d.pc_source = PCS_JMP;
      end
      S_HALT:  out_d.halted = 1'b1;
      S_ERROR: out_d.error  = 1'b1;
      default: out_d = '0;
    endcase
  end

  // The fetch completes on the ready cycle itself, so the
  // IR/PC latch is the registered fetch request qualified
  // by ready; everything else comes straight off out_q.
  assign bus.output_PCWrite     = out_q.pc_write | ifetch;
  assign bus.output_IRWrite     = ifetch;
  assign bus.output_PC_isbranch = out_q.pc_isbranch;
  assign bus.output_branchType  = out_q.branch_type;
  assign bus.output_PCSource    = out_q.pc_source;
  assign bus.output_IorD        = out_q.iord;
  assign bus.output_MemRead     = out_q.mem_read;
  assign bus.output_MemWrite    = out_q.mem_write;
  assign bus.output_RegWrite    = out_q.reg_write;
  assign bus.output_MemtoReg    = out_q.memtoreg;
  assign bus.output_ALUSrcA     = out_q.alusrca;
  assign bus.output_ALUSrcB     = out_q.alusrcb;
  assign bus.output_ALUOp       = out_q.aluop;
  assign bus.output_halted      = out_q.halted;
  assign bus.output_error       = out_q.error;

endmodule
